// File: rtl/black_box_sequence_checker_pkg.sv
// Shared definitions for the sink-side sequence checker black box.
package black_box_sequence_checker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] NO_INDEX = 16'hFFFF;

    // Mismatch counter sticks at all-ones rather than wrapping back to a "clean" value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/black_box_sequence_generator.sv
// WIDTH-bit expected-value accumulator: loads START, advances by STEP, wraps modulo 2^WIDTH.
module black_box_sequence_generator #(
    parameter int unsigned WIDTH = 16,
    parameter logic [63:0] START = 64'd0,
    parameter logic [63:0] STEP  = 64'd1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] START_W = START[WIDTH-1:0];
    localparam logic [WIDTH-1:0] STEP_W  = STEP[WIDTH-1:0];

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = START_W;
        end else if (advance) begin
            value_d = value_q + STEP_W;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q <= START_W;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/black_box_sequence_checker.sv
// Valid/ready sink that checks COUNT samples against START + i*STEP and reports registered results.
module black_box_sequence_checker
    import black_box_sequence_checker_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter logic [63:0] START = 64'd0,
    parameter logic [63:0] STEP  = 64'd1,
    parameter int unsigned COUNT = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bits,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatches,
    output logic [CNT_W-1:0] first_bad_index,
    output logic [CNT_W-1:0] received
);

    localparam logic [CNT_W-1:0] COUNT_W  = CNT_W'(COUNT);
    localparam logic [CNT_W-1:0] LAST_IDX = COUNT_W - CNT_W'(1);

    state_e           state_q, state_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] mis_q, mis_d;
    logic [CNT_W-1:0] first_q, first_d;
    logic [CNT_W-1:0] recv_q, recv_d;

    logic             gen_load;
    logic             gen_advance;
    logic [WIDTH-1:0] expected;
    logic             accept;
    logic             bad;

    black_box_sequence_generator #(
        .WIDTH (WIDTH),
        .START (START),
        .STEP  (STEP)
    ) u_gen (
        .clock   (clock),
        .reset   (reset),
        .load    (gen_load),
        .advance (gen_advance),
        .value   (expected)
    );

    assign accept = ready_q && in_valid;
    assign bad    = accept && (in_bits != expected);

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        pass_d      = pass_q;
        mis_d       = mis_q;
        first_d     = first_q;
        recv_d      = recv_q;
        gen_load    = 1'b0;
        gen_advance = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mis_d    = '0;
                    recv_d   = '0;
                    first_d  = NO_INDEX;
                    gen_load = 1'b1;
                    if (COUNT_W == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (bad) begin
                        mis_d = sat_inc(mis_q);
                        if (first_q == NO_INDEX) begin
                            first_d = recv_q;
                        end
                    end
                    recv_d      = recv_q + CNT_W'(1);
                    gen_advance = 1'b1;
                    // pass includes the compare of the final sample via mis_d
                    if (recv_q == LAST_IDX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (mis_d == '0);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mis_q   <= '0;
            first_q <= NO_INDEX;
            recv_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mis_q   <= mis_d;
            first_q <= first_d;
            recv_q  <= recv_d;
        end
    end

    assign in_ready        = ready_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign mismatches      = mis_q;
    assign first_bad_index = first_q;
    assign received        = recv_q;

endmodule

// File: tb/tb_black_box_sequence_checker.sv
// Four checker instances with different parameter sets, compared every cycle against a sample-index model.
module tb_black_box_sequence_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  st = '0;
    logic [3:0]  vl = '0;
    logic [3:0]  rdy, dn, ps;
    logic [63:0] bits [4];
    logic [15:0] mis [4];
    logic [15:0] fbi [4];
    logic [15:0] rcv [4];

    int checks   = 0;
    int failures = 0;

    longint unsigned PW  [4] = '{16, 8, 16, 12};
    longint unsigned PS  [4] = '{0, 'hFE, 5, 'h12FF0};
    longint unsigned PST [4] = '{1, 1, 3, 'h100A};
    longint unsigned PC  [4] = '{8, 4, 0, 5};

    bit          m_run  [4];
    bit          m_done [4];
    bit          m_pass [4];
    int unsigned m_mis  [4];
    int unsigned m_first[4];
    int unsigned m_recv [4];

    always #5 clock = ~clock;

    black_box_sequence_checker #(.WIDTH(16), .START(64'd0), .STEP(64'd1), .COUNT(8)) u0 (
        .clock(clock), .reset(reset), .start(st[0]), .in_valid(vl[0]), .in_ready(rdy[0]),
        .in_bits(bits[0][15:0]), .done(dn[0]), .pass(ps[0]), .mismatches(mis[0]),
        .first_bad_index(fbi[0]), .received(rcv[0]));

    black_box_sequence_checker #(.WIDTH(8), .START(64'hFE), .STEP(64'd1), .COUNT(4)) u1 (
        .clock(clock), .reset(reset), .start(st[1]), .in_valid(vl[1]), .in_ready(rdy[1]),
        .in_bits(bits[1][7:0]), .done(dn[1]), .pass(ps[1]), .mismatches(mis[1]),
        .first_bad_index(fbi[1]), .received(rcv[1]));

    black_box_sequence_checker #(.WIDTH(16), .START(64'd5), .STEP(64'd3), .COUNT(0)) u2 (
        .clock(clock), .reset(reset), .start(st[2]), .in_valid(vl[2]), .in_ready(rdy[2]),
        .in_bits(bits[2][15:0]), .done(dn[2]), .pass(ps[2]), .mismatches(mis[2]),
        .first_bad_index(fbi[2]), .received(rcv[2]));

    black_box_sequence_checker #(.WIDTH(12), .START(64'h12FF0), .STEP(64'h100A), .COUNT(5)) u3 (
        .clock(clock), .reset(reset), .start(st[3]), .in_valid(vl[3]), .in_ready(rdy[3]),
        .in_bits(bits[3][11:0]), .done(dn[3]), .pass(ps[3]), .mismatches(mis[3]),
        .first_bad_index(fbi[3]), .received(rcv[3]));

    function automatic logic [63:0] mask(int k);
        return (PW[k] == 64) ? '1 : ((64'd1 << PW[k]) - 64'd1);
    endfunction

    // Expected sample i straight from the closed form, not an accumulator.
    function automatic logic [63:0] exp_val(int k, longint unsigned i);
        return (PS[k] + i * PST[k]) & mask(k);
    endfunction

    task automatic check(string tag, int k, logic [63:0] obs, logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_run[k]   = 1'b0;
            m_done[k]  = 1'b0;
            m_pass[k]  = 1'b0;
            m_mis[k]   = 0;
            m_first[k] = 16'hFFFF;
            m_recv[k]  = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            if (m_run[k]) begin
                if (vl[k]) begin
                    if ((bits[k] & mask(k)) != exp_val(k, m_recv[k])) begin
                        if (m_mis[k] < 65535) m_mis[k]++;
                        if (m_first[k] == 16'hFFFF) m_first[k] = m_recv[k];
                    end
                    m_recv[k]++;
                    if (m_recv[k] == PC[k]) begin
                        m_run[k]  = 1'b0;
                        m_done[k] = 1'b1;
                        m_pass[k] = (m_mis[k] == 0);
                    end
                end
            end else if (st[k]) begin
                m_mis[k]   = 0;
                m_recv[k]  = 0;
                m_first[k] = 16'hFFFF;
                if (PC[k] == 0) begin
                    m_done[k] = 1'b1;
                    m_pass[k] = 1'b1;
                end else begin
                    m_run[k]  = 1'b1;
                    m_done[k] = 1'b0;
                    m_pass[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            check("in_ready", k, rdy[k], m_run[k]);
            check("done", k, dn[k], m_done[k]);
            check("pass", k, ps[k], m_pass[k]);
            check("mismatches", k, mis[k], m_mis[k]);
            check("first_bad_index", k, fbi[k], m_first[k]);
            check("received", k, rcv[k], m_recv[k]);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check_all();
        st = '0;
    endtask

    task automatic feed(int k, bit v, bit corrupt);
        vl[k] = v;
        if (v) bits[k] = corrupt ? (exp_val(k, m_recv[k]) ^ 64'd1) : exp_val(k, m_recv[k]);
        else   bits[k] = {$urandom, $urandom};
    endtask

    // Reset raised between edges; outputs must drop without waiting for a clock.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;
        st = '0;
        vl = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] t3v [4];
        int guard;
        t3v = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        for (int k = 0; k < 4; k++) bits[k] = '0;
        model_reset();
        #12;
        check_all();
        reset = 1'b0;
        step();

        // Clean back-to-back run 0..7
        st[0] = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            vl[0] = 1'b1;
            bits[0] = 64'(i);
            step();
        end
        vl[0] = 1'b0;
        check("t1_pass", 0, ps[0], 1);
        check("t1_received", 0, rcv[0], 8);
        check("t1_first_bad", 0, fbi[0], 64'hFFFF);
        step();

        // Two corrupted samples at indices 3 and 6
        st[0] = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            vl[0] = 1'b1;
            bits[0] = (i == 3) ? 64'hFF : (i == 6) ? 64'd0 : 64'(i);
            step();
        end
        vl[0] = 1'b0;
        check("t2_pass", 0, ps[0], 0);
        check("t2_mismatches", 0, mis[0], 2);
        check("t2_first_bad", 0, fbi[0], 3);

        // 8-bit wrap with alternating valid, plus COUNT==0 instance
        st[1] = 1'b1;
        st[2] = 1'b1;
        vl[2] = 1'b1;
        step();
        vl[2] = 1'b0;
        check("t4_done", 2, dn[2], 1);
        check("t4_pass", 2, ps[2], 1);
        for (int j = 0; j < 8; j++) begin
            vl[1] = j[0];
            bits[1] = {56'd0, t3v[j / 2]};
            step();
        end
        vl[1] = 1'b0;
        check("t3_done", 1, dn[1], 1);
        check("t3_pass", 1, ps[1], 1);
        check("t3_received", 1, rcv[1], 4);

        // Reset mid-run at received==3, then a stalled but correct run
        st[0] = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            feed(0, 1'b1, 1'b0);
            step();
        end
        vl[0] = 1'b0;
        async_reset();
        st[0] = 1'b1;
        step();
        guard = 0;
        while (m_run[0] && guard < 100) begin
            feed(0, 1'($urandom_range(0, 1)), 1'b0);
            step();
            guard++;
        end
        vl[0] = 1'b0;
        check("t5_done", 0, dn[0], 1);
        check("t5_pass", 0, ps[0], 1);

        // start pulsed during RUN at received==2 is ignored
        st[0] = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            if (i == 2) st[0] = 1'b1;
            feed(0, 1'b1, 1'b0);
            step();
        end
        vl[0] = 1'b0;
        check("t6_received", 0, rcv[0], 8);
        check("t6_pass", 0, ps[0], 1);

        // Randomised traffic on all instances
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) begin
                st[k] = ($urandom_range(0, 15) == 0);
                feed(k, $urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 149) == 0) async_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
